// File: rtl/mdu_iter_if.sv
// Request/result bundle between the EX-stage control and the iterative multiply/divide unit.
// master = control FSM side, slave = mdu_iter.
`timescale 1ns/1ps
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, srcA, srcB, cancel, hi_we, lo_we, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, srcA, srcB, cancel, hi_we, lo_we, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: WIDTH+1 cycles accept-to-result, done pulses one cycle later.
// No backpressure: start is ignored while busy, the caller stalls on busy.
`timescale 1ns/1ps
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  mdu_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   bmag;
  logic [WIDTH-1:0]   araw;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag_in;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] acc_mul;
  logic [WIDTH:0]     dshift;
  logic [WIDTH:0]     ddiff;
  logic [2*WIDTH-1:0] acc_div;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo_f;
  logic [WIDTH-1:0]   rem_f;

  assign accept  = bus.start && (state == IDLE || state == DONE);
  assign a_neg   = ~bus.op[0] & bus.srcA[WIDTH-1];
  assign b_neg   = ~bus.op[0] & bus.srcB[WIDTH-1];
  assign amag    = a_neg ? -bus.srcA : bus.srcA;
  assign bmag_in = b_neg ? -bus.srcB : bus.srcB;

  // acc low half starts as |A|: multiplier bits for multiply, dividend bits for divide
  assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag} : {(WIDTH+1){1'b0}});
  assign acc_mul = {msum, acc[WIDTH-1:1]};

  // acc upper half is the partial remainder; the shifted-in bit forms the guard position
  assign dshift  = acc[2*WIDTH-1:WIDTH-1];
  assign ddiff   = dshift - {1'b0, bmag};
  assign acc_div = ddiff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_f  = neg_q ? -acc : acc;
  assign quo_f   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_f   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      bmag   <= '0;
      araw   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= CALC;
            cnt    <= CW'(WIDTH);
            acc    <= {{WIDTH{1'b0}}, amag};
            bmag   <= bmag_in;
            araw   <= bus.srcA;
            is_div <= bus.op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
          end else begin
            state <= IDLE;
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        CALC: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else begin
            acc <= is_div ? acc_div : acc_mul;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else begin
            state <= DONE;
            if (!is_div) begin
              {hi_r, lo_r} <= prod_f;
            end else if (bmag == '0) begin
              // divide by zero: raw dividend in HI, all ones in LO, no sign fix
              hi_r <= araw;
              lo_r <= '1;
            end else begin
              hi_r <= rem_f;
              lo_r <= quo_f;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == CALC) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative, parametrised multiply/divide unit for the multicycle MIPS datapath. It executes MULT, MULTU, DIV and DIVU over WIDTH cycles using a start/busy/done handshake, and holds the results in HI/LO registers. It also services MTHI/MTLO writes. It sits beside the combinational ALU in the EX stage; the control FSM stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand and HI/LO width, ≥ 2.
- `clk`  in  1: clock; all state changes on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request an operation; accepted only when `busy`=0.
- `op`  in  2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with accepted `start`.
- `srcA`  in  WIDTH: multiplicand / dividend; sampled with accepted `start`.
- `srcB`  in  WIDTH: multiplier / divisor; sampled with accepted `start`.
- `cancel`  in  1: abort an in-flight operation (exception flush).
- `hi_we`  in  1: MTHI write strobe.
- `lo_we`  in  1: MTLO write strobe.
- `wdata`  in  WIDTH: MTHI/MTLO data.
- `busy`  out  1: operation in flight.
- `done`  out  1: one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH: HI register (product upper half / remainder).
- `lo`  out  WIDTH: LO register (product lower half / quotient).

## Operation
- States: IDLE, CALC, FIX, DONE. Reset → IDLE with `hi`=`lo`=0 and `busy`=`done`=0.
- **IDLE or DONE, `start`=1:** latch `op` and the operands, then enter CALC with counter = WIDTH.
  - Signed ops store magnitudes and record the result signs: product sign = sign(A)^sign(B); quotient sign same; remainder sign = sign(A).
- **CALC, multiply:** shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **CALC, divide:** restoring division, one quotient bit per cycle, into a WIDTH-bit partial remainder plus one guard bit.
- **CALC exit:** the counter decrements each cycle; at 0 → FIX.
- **FIX:** apply two's-complement negation per the recorded signs. Write HI/LO:
  - multiply: {hi,lo} = product.
  - divide: hi = remainder, lo = quotient.
  - Then → DONE.
- **DONE:** `done`=1 for exactly this cycle.
  - → CALC if `start`=1 (back-to-back op).
  - Otherwise → IDLE.
- **Signed division semantics:** quotient truncates toward zero; remainder has the sign of the dividend.
- **Divide by zero (`srcB`=0, DIV or DIVU):** lo = all ones, hi = `srcA` unchanged, no sign fix. Same latency. No error flag.
- **Signed overflow, most-negative / −1:** lo = most-negative value, hi = 0. This is the natural result of the magnitude datapath.
- **`start` while `busy`=1:** ignored. The operands are not resampled.
- **`hi_we`/`lo_we`:** honoured only in IDLE or DONE, and write `hi`/`lo` at the edge.
  - Ignored while `busy`=1.
  - Ignored in a cycle where `start` is accepted (start wins).
  - `hi_we` and `lo_we` both set writes `wdata` to both registers.
- **`cancel`:** in CALC or FIX, → IDLE at the next edge. HI/LO are unchanged and no `done` is issued. In IDLE or DONE it has no effect.
- **`rst` mid-operation:** immediate IDLE; HI/LO cleared to 0.

## Timing
- `start` accepted at edge *t*:
  - `busy`=1 from after edge *t* through edge *t*+WIDTH+1 (CALC = WIDTH cycles, FIX = 1 cycle).
  - HI/LO updated at edge *t*+WIDTH+1.
  - `done`=1 during the cycle after edge *t*+WIDTH+1; `busy`=0 in that cycle.
- Total latency is WIDTH+1 cycles from accept to result visible, independent of operand values.
- Throughput: one operation per WIDTH+2 cycles; a `start` during DONE is accepted.
- `busy` and `done` are registered (decoded from state flops), never both high.
- `hi` and `lo` are registered outputs; they are stable while `busy`=1 except for the FIX write edge.
- The counter is sized to hold 0..WIDTH.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `done` in cycle *t*+34; `busy` high for exactly 33 cycles.
- **MULT:** −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- **MULT:** 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- **DIVU:** 100 / 7 → lo=14, hi=2.
- **DIV:** −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **DIV:** 7 / −2 → lo=0xFFFFFFFD, hi=1.
- **DIV:** 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- **DIVU/DIV:** 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234.
- **Handshake:**
  - `start` with new operands pulsed at cycle 5 of a busy op → ignored; result matches the original operands.
  - Back-to-back `start` in the DONE cycle → second result after another WIDTH+1 cycles.
- **Cancel/reset/MTHI:**
  - `cancel` at CALC cycle 10 → IDLE next edge, no `done`, HI/LO keep prior values.
  - `rst` mid-CALC → hi=lo=0 and `busy`=0 immediately.
  - `hi_we` with `wdata`=0xDEADBEEF in IDLE → hi=0xDEADBEEF; the same write while busy is dropped.
